// File: rtl/axis_parity_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter requester side (N lanes) and the tester side (1 lane).
// Lane i occupies tdata[8i+7:8i].
interface axis_parity_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0]   tvalid;
    logic [8*N-1:0] tdata;
    logic [N-1:0]   tlast;
    logic [N-1:0]   tready;

    modport master (output tvalid, output tdata, output tlast, input  tready);
    modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/axis_parity_arbiter.sv
// Round-robin packet arbiter sharing one 8-bit AXI-Stream parity tester between N_REQ requesters.
// Define PKT_PARITY_EN to add the per-packet parity outputs pkt_parity / pkt_parity_vld.
module axis_parity_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                  a_clk,
    input  logic                  axis_aresetn,
    axis_parity_arbiter_if.slave  axis_s,
    axis_parity_arbiter_if.master axis_m,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  abort_pulse
`ifdef PKT_PARITY_EN
    ,
    output logic                  pkt_parity,
    output logic                  pkt_parity_vld
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, ABORT = 2'd2} state_t;

    localparam int WD_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = '1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(IDLE_TIMEOUT);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d, ptr_q, ptr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [7:0]        m_data_q, m_data_d;
    logic              abort_q, abort_d;

    logic              s_room, sel_valid, sel_last, accept, load;
    logic [7:0]        sel_data;
    logic [N_REQ-1:0]  s_tready;
    logic              found_hi, found_lo;
    logic [ID_W-1:0]   win_hi, win_lo;

    assign s_room = !m_valid_q || axis_m.tready;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        s_tready  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_q) begin
                sel_valid   = axis_s.tvalid[i];
                sel_data    = axis_s.tdata[8*i +: 8];
                sel_last    = axis_s.tlast[i];
                s_tready[i] = (state_q == XFER) && s_room;
            end
        end
    end

    assign accept = (state_q == XFER) && sel_valid && s_room;

    // Round-robin search split in two ascending passes: indices above ptr first, then the wrap-around part.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found_hi && axis_s.tvalid[i] && (ID_W'(i) > ptr_q)) begin
                found_hi = 1'b1;
                win_hi   = ID_W'(i);
            end
            if (!found_lo && axis_s.tvalid[i] && (ID_W'(i) <= ptr_q)) begin
                found_lo = 1'b1;
                win_lo   = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        abort_d   = 1'b0;
        load      = 1'b0;
        m_valid_d = m_valid_q && !axis_m.tready;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        unique case (state_q)
            IDLE: begin
                wd_d = '0;
                if (found_hi || found_lo) begin
                    grant_d = found_hi ? win_hi : win_lo;
                    ptr_d   = found_hi ? win_hi : win_lo;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    load     = 1'b1;
                    m_data_d = sel_data;
                    m_last_d = sel_last;
                    wd_d     = '0;
                    if (sel_last) state_d = IDLE;
                end else if (!sel_valid && (IDLE_TIMEOUT != 0)) begin
                    wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
                    if (wd_d >= WD_LIM) begin
                        state_d = ABORT;
                        wd_d    = '0;
                    end
                end
            end
            ABORT: begin
                wd_d = '0;
                // Closing beat waits for the output register so a held beat is never overwritten.
                if (s_room) begin
                    load     = 1'b1;
                    m_data_d = 8'h00;
                    m_last_d = 1'b1;
                    abort_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) m_valid_d = 1'b1;
    end

    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
            wd_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            abort_q   <= abort_d;
        end
    end

    assign axis_s.tready = s_tready;
    assign axis_m.tvalid = m_valid_q;
    assign axis_m.tdata  = m_data_q;
    assign axis_m.tlast  = m_last_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q == XFER);
    assign abort_pulse   = abort_q;

`ifdef PKT_PARITY_EN
    logic acc_q, par_q, par_vld_q;

    always_ff @(posedge a_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            acc_q     <= 1'b0;
            par_q     <= 1'b0;
            par_vld_q <= 1'b0;
        end else begin
            par_vld_q <= 1'b0;
            if (load) begin
                if (m_last_d) begin
                    par_q     <= acc_q ^ (^m_data_d);
                    par_vld_q <= 1'b1;
                    acc_q     <= 1'b0;
                end else begin
                    acc_q <= acc_q ^ (^m_data_d);
                end
            end
        end
    end

    assign pkt_parity     = par_q;
    assign pkt_parity_vld = par_vld_q;
`endif
endmodule

// File: tb/tb_axis_parity_arbiter.sv
// Directed self-checking bench for axis_parity_arbiter (4 requesters, IDLE_TIMEOUT=16).
// Parity checks are compiled in only when PKT_PARITY_EN is defined.
module tb_axis_parity_arbiter;
    localparam int N_REQ = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant_id;
    logic       busy, abort_pulse;
`ifdef PKT_PARITY_EN
    logic       pkt_parity, pkt_parity_vld;
    logic       p_q[$];
`endif

    axis_parity_arbiter_if #(.N(N_REQ)) s_if ();
    axis_parity_arbiter_if #(.N(1))     m_if ();

    axis_parity_arbiter #(
        .N_REQ        (N_REQ),
        .ID_W         (2),
        .IDLE_TIMEOUT (16)
    ) dut (
        .a_clk        (clk),
        .axis_aresetn (rst_n),
        .axis_s       (s_if),
        .axis_m       (m_if),
        .grant_id     (grant_id),
        .busy         (busy),
        .abort_pulse  (abort_pulse)
`ifdef PKT_PARITY_EN
        ,
        .pkt_parity     (pkt_parity),
        .pkt_parity_vld (pkt_parity_vld)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  q_d[$];
    logic        q_l[$];
    int unsigned q_t[$];

    always @(negedge clk) begin
        if (rst_n && m_if.tvalid[0] && m_if.tready[0]) begin
            q_d.push_back(m_if.tdata);
            q_l.push_back(m_if.tlast[0]);
            q_t.push_back(cyc);
        end
`ifdef PKT_PARITY_EN
        if (rst_n && pkt_parity_vld) p_q.push_back(pkt_parity);
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_q();
        q_d.delete();
        q_l.delete();
        q_t.delete();
    endtask

    task automatic send_beat(input int r, input logic [7:0] d, input logic l);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        s_if.tvalid[r]       = 1'b1;
        s_if.tdata[8*r +: 8] = d;
        s_if.tlast[r]        = l;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_if.tready[r];
            @(posedge clk);
            #1;
            n++;
        end
        s_if.tvalid[r] = 1'b0;
        s_if.tlast[r]  = 1'b0;
        if (!acc) chk($sformatf("send_timeout_r%0d", r), {31'b0, acc}, 32'd1);
    endtask

    task automatic send_pkt3(input int r, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        send_beat(r, d0, 1'b0);
        send_beat(r, d1, 1'b0);
        send_beat(r, d2, 1'b1);
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k;
        k = 0;
        while (q_d.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk(tag, q_d.size(), n);
    endtask

    logic t3_on;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        s_if.tvalid = '1;
        s_if.tdata  = {4{8'h5a}};
        s_if.tlast  = '0;
        m_if.tready = 1'b1;
        t3_on       = 1'b0;

        // T1: reset with all requesters valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_m_tdata", m_if.tdata, 0);
        chk("rst_m_tlast", m_if.tlast, 0);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort_pulse, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("arb_grant", grant_id, 0);
        chk("arb_busy", busy, 1);
        chk("arb_no_beat", m_if.tvalid, 0);
        chk("arb_s_tready", s_if.tready, 4'b0001);
        @(negedge clk);
        chk("first_beat_vld", m_if.tvalid, 1);
        chk("first_beat_data", m_if.tdata, 8'h5a);
        rst_n = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_if.tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_tready", s_if.tready, 0);
        s_if.tvalid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear_q();

        // T2: round robin, all four requesters
        fork
            begin send_pkt3(0, 8'h00, 8'h01, 8'h02); send_pkt3(0, 8'h00, 8'h01, 8'h02); end
            send_pkt3(1, 8'h10, 8'h11, 8'h12);
            send_pkt3(2, 8'h20, 8'h21, 8'h22);
            send_pkt3(3, 8'h30, 8'h31, 8'h32);
        join
        wait_beats(15, "rr_count");
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("rr_data%0d", j), q_d[j], 32'(16 * ((j / 3) % 4) + (j % 3)));
            chk($sformatf("rr_last%0d", j), q_l[j], (j % 3 == 2) ? 1 : 0);
            if (j > 0) chk($sformatf("rr_gap%0d", j), q_t[j] - q_t[j-1], (j % 3 == 0) ? 2 : 1);
        end
        clear_q();

        // T3: backpressure toggling every cycle
        t3_on = 1'b1;
        fork
            begin
                send_pkt3(2, 8'hab, 8'h12, 8'hde);
                wait_beats(3, "bp_count");
                t3_on = 1'b0;
            end
            begin
                while (t3_on) begin
                    @(posedge clk);
                    #1 m_if.tready = ~m_if.tready;
                end
            end
        join
        m_if.tready = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_no_dup", q_d.size(), 3);
        chk("bp_d0", q_d[0], 8'hab);
        chk("bp_d1", q_d[1], 8'h12);
        chk("bp_d2", q_d[2], 8'hde);
        chk("bp_lasts", {q_l[0], q_l[1], q_l[2]}, 3'b001);
        clear_q();

        // T4: lone requester, single-beat packets
        repeat (3) send_beat(3, 8'hff, 1'b1);
        wait_beats(3, "single_count");
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("single_data%0d", j), q_d[j], 8'hff);
            chk($sformatf("single_last%0d", j), q_l[j], 1);
            if (j > 0) chk($sformatf("single_gap%0d", j), q_t[j] - q_t[j-1], 2);
        end
        chk("single_grant", grant_id, 3);
        clear_q();

        // T5: watchdog abort
        send_beat(1, 8'h77, 1'b0);
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!abort_pulse && k < 60) begin
                @(negedge clk);
                k++;
            end
        end
        chk("wd_abort_pulse", abort_pulse, 1);
        chk("wd_m_tvalid", m_if.tvalid, 1);
        chk("wd_m_tdata", m_if.tdata, 8'h00);
        chk("wd_m_tlast", m_if.tlast, 1);
        chk("wd_busy", busy, 0);
        @(negedge clk);
        chk("wd_pulse_1cyc", abort_pulse, 0);
        chk("wd_count", q_d.size(), 2);
        chk("wd_beat0", {q_d[0], 7'b0, q_l[0]}, {8'h77, 8'h00});
        chk("wd_beat1", {q_d[1], 7'b0, q_l[1]}, {8'h00, 8'h01});
        chk("wd_latency", q_t[1] - q_t[0], 17);
        send_beat(1, 8'h88, 1'b1);
        wait_beats(3, "wd_newpkt_count");
        chk("wd_newpkt", {q_d[2], 7'b0, q_l[2]}, {8'h88, 8'h01});
        clear_q();

`ifdef PKT_PARITY_EN
        // T6: packet parity (bit-count parity over all loaded beats)
        p_q.delete();
        send_pkt3(0, 8'h01, 8'h03, 8'h07);
        send_beat(0, 8'h03, 1'b1);
        send_beat(0, 8'h07, 1'b1);
        send_pkt3(0, 8'h01, 8'h02, 8'h04);
        wait_beats(8, "par_beats");
        chk("par_count", p_q.size(), 4);
        chk("par_010307", p_q[0], 0);
        chk("par_03", p_q[1], 0);
        chk("par_07", p_q[2], 1);
        chk("par_010204", p_q[3], 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
